// File: rtl/song_recorder_if.sv
// song_recorder_if: groups the note-capture inputs and the status / read-port
// outputs of song_recorder.
//   master (stimulus side): drives key_on, key, start, stop, rd_en, rd_addr;
//                           observes recording, full, note_count, rd_valid,
//                           rd_key, rd_dur
//   slave  (recorder side): the opposite directions
interface song_recorder_if #(
  parameter int DUR_W = 8
);
  logic             key_on;
  logic [3:0]       key;
  logic             start;
  logic             stop;
  logic             rd_en;
  logic [5:0]       rd_addr;
  logic             recording;
  logic             full;
  logic [5:0]       note_count;
  logic             rd_valid;
  logic [3:0]       rd_key;
  logic [DUR_W-1:0] rd_dur;

  modport master (
    output key_on, key, start, stop, rd_en, rd_addr,
    input  recording, full, note_count, rd_valid, rd_key, rd_dur
  );

  modport slave (
    input  key_on, key, start, stop, rd_en, rd_addr,
    output recording, full, note_count, rd_valid, rd_key, rd_dur
  );
endinterface

// File: rtl/song_recorder.sv
// song_recorder: captures a live key_on/key note stream into an indexed song
// memory. Each slot holds {key, duration}, with the duration measured from
// one note onset to the next onset (or to stop) in prescaled tick units.
//   clk, rst       : system clock, synchronous active-high reset
//   bus.key_on/key : live note stream (level + 4-bit note index)
//   bus.start/stop : one-cycle pulses arming / finalizing a recording
//   bus.rd_en/addr : read strobe and slot index (1-cycle registered read)
//   bus.recording  : high while armed or capturing
//   bus.full       : all DEPTH slots written
//   bus.note_count : number of stored notes
//   bus.rd_valid/rd_key/rd_dur : registered read result
module song_recorder #(
  parameter int DEPTH       = 32,
  parameter int TICK_CYCLES = 1000000,
  parameter int DUR_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  song_recorder_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [DUR_W-1:0] DUR_MAX    = '1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0]    COUNT_LAST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t           state;
  logic             key_on_p1;
  logic [3:0]       key_p1;
  logic [PW-1:0]    presc;
  logic [DUR_W-1:0] ticks;
  logic [3:0]       pend_key;
  logic [CW-1:0]    count;
  logic             rec_r;
  logic             full_r;
  logic             rd_valid_r;
  logic [3:0]       rd_key_r;
  logic [DUR_W-1:0] rd_dur_r;
  logic [4+DUR_W-1:0] mem [DEPTH];

  logic             tick_wrap;
  logic             onset;
  logic             wr_en;
  logic             fill;
  logic [DUR_W-1:0] dur_now;
  logic             unused_rd_addr;

  function automatic logic [DUR_W-1:0] sat_inc(input logic [DUR_W-1:0] t,
                                               input logic inc);
    if (inc && (t != DUR_MAX)) return t + DUR_W'(1);
    return t;
  endfunction

  function automatic logic [DUR_W-1:0] floor_one(input logic [DUR_W-1:0] t);
    return (t == '0) ? DUR_W'(1) : t;
  endfunction

  // Stage p0: onset detection against the previous-cycle key registers and
  // the duration as it will stand once this edge's tick has been counted.
  always_comb begin
    tick_wrap = (presc == PRESC_LAST);
    dur_now   = floor_one(sat_inc(ticks, tick_wrap));
    onset     = bus.key_on && (!key_on_p1 || (bus.key != key_p1));
    wr_en     = (state == CAPTURE) && (bus.stop || onset);
    fill      = wr_en && (count == COUNT_LAST);
  end

  assign unused_rd_addr = ^(bus.rd_addr >> AW);

  // Stage p1: capture FSM, timers and previous-key registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rec_r     <= 1'b0;
      full_r    <= 1'b0;
      count     <= '0;
      pend_key  <= '0;
      presc     <= '0;
      ticks     <= '0;
      key_on_p1 <= 1'b0;
      key_p1    <= '0;
    end else begin
      key_on_p1 <= bus.key_on;
      key_p1    <= bus.key;
      if (tick_wrap) begin
        presc <= '0;
        ticks <= sat_inc(ticks, 1'b1);
      end else begin
        presc <= presc + PW'(1);
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= ARMED;
            rec_r  <= 1'b1;
            count  <= '0;
            full_r <= 1'b0;
          end
        end
        ARMED: begin
          if (bus.stop) begin
            state <= IDLE;
            rec_r <= 1'b0;
          end else if (onset) begin
            state    <= CAPTURE;
            pend_key <= bus.key;
            presc    <= '0;
            ticks    <= '0;
          end
        end
        CAPTURE: begin
          if (wr_en) begin
            count <= count + CW'(1);
            if (fill) full_r <= 1'b1;
            // stop outranks the onset; a filling write drops the new onset.
            if (bus.stop || fill) begin
              state <= IDLE;
              rec_r <= 1'b0;
            end else begin
              pend_key <= bus.key;
              presc    <= '0;
              ticks    <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          rec_r <= 1'b0;
        end
      endcase
    end
  end

  // Stage p1: song memory write (contents are not reset).
  always_ff @(posedge clk) begin
    if (wr_en) mem[count[AW-1:0]] <= {pend_key, dur_now};
  end

  // Stage p1: registered read port; a same-edge write is not visible here.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      rd_key_r   <= '0;
      rd_dur_r   <= '0;
    end else begin
      rd_valid_r <= bus.rd_en;
      if (bus.rd_en) {rd_key_r, rd_dur_r} <= mem[bus.rd_addr[AW-1:0]];
    end
  end

  assign bus.recording  = rec_r;
  assign bus.full       = full_r;
  // At DEPTH=64 the 64-note count wraps to 0 here; full distinguishes it.
  assign bus.note_count = 6'(count);
  assign bus.rd_valid   = rd_valid_r;
  assign bus.rd_key     = rd_key_r;
  assign bus.rd_dur     = rd_dur_r;
endmodule

// File: tb/tb_song_recorder.sv
// tb_song_recorder: directed scenarios plus randomized stimulus for
// song_recorder (DEPTH=4, TICK_CYCLES=4, DUR_W=4), checked every cycle
// against a note-level reference model of the recorder.
module tb_song_recorder;
  localparam int DEPTH = 4;
  localparam int TICK  = 4;
  localparam int DUR_W = 4;
  localparam int DMAX  = (1 << DUR_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  song_recorder_if #(.DUR_W(DUR_W)) bus ();

  song_recorder #(
    .DEPTH(DEPTH),
    .TICK_CYCLES(TICK),
    .DUR_W(DUR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: recording session, pending note, stored song.
  bit m_rec, m_pend, m_full;
  int m_count, m_pkey, m_onset_edge, edge_no;
  bit m_prev_on;
  int m_prev_key;
  int m_mkey [DEPTH];
  int m_mdur [DEPTH];
  bit m_wr   [DEPTH];
  bit m_rd_valid, m_rd_known;
  int m_rd_key, m_rd_dur;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  function automatic int note_dur();
    int d;
    d = (edge_no - m_onset_edge) / TICK;
    if (d < 1) d = 1;
    if (d > DMAX) d = DMAX;
    return d;
  endfunction

  task automatic store_note();
    m_mkey[m_count] = m_pkey;
    m_mdur[m_count] = note_dur();
    m_wr[m_count]   = 1'b1;
    m_count++;
    if (m_count == DEPTH) m_full = 1'b1;
  endtask

  task automatic model_edge();
    bit onset;
    int a;
    if (rst) begin
      m_rec = 0; m_pend = 0; m_full = 0; m_count = 0;
      m_prev_on = 0; m_prev_key = 0;
      m_rd_valid = 0; m_rd_known = 1; m_rd_key = 0; m_rd_dur = 0;
      for (int i = 0; i < DEPTH; i++) m_wr[i] = 1'b0;
    end else begin
      a = int'(bus.rd_addr) % DEPTH;
      m_rd_valid = bus.rd_en;
      if (bus.rd_en) begin
        m_rd_known = m_wr[a];
        m_rd_key   = m_mkey[a];
        m_rd_dur   = m_mdur[a];
      end
      onset = bus.key_on && (!m_prev_on || (int'(bus.key) != m_prev_key));
      if (!m_rec) begin
        if (bus.start) begin
          m_rec = 1; m_pend = 0; m_count = 0; m_full = 0;
        end
      end else if (bus.stop) begin
        if (m_pend) store_note();
        m_rec = 0; m_pend = 0;
      end else if (onset) begin
        if (!m_pend) begin
          m_pend = 1; m_pkey = int'(bus.key); m_onset_edge = edge_no;
        end else begin
          store_note();
          if (m_full) begin
            m_rec = 0; m_pend = 0;
          end else begin
            m_pkey = int'(bus.key); m_onset_edge = edge_no;
          end
        end
      end
      m_prev_on  = bus.key_on;
      m_prev_key = int'(bus.key);
    end
    edge_no++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("recording", bus.recording, m_rec);
    check_eq("full", bus.full, m_full);
    check_eq("note_count", bus.note_count, m_count);
    check_eq("rd_valid", bus.rd_valid, m_rd_valid);
    if (m_rd_known) begin
      check_eq("rd_key", bus.rd_key, m_rd_key);
      check_eq("rd_dur", bus.rd_dur, m_rd_dur);
    end
  endtask

  task automatic start_pulse();
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
  endtask

  task automatic stop_pulse();
    bus.stop = 1'b1; cycle(); bus.stop = 1'b0;
  endtask

  task automatic read_expect(input int a, input int k, input int d, input string tag);
    bus.rd_en = 1'b1; bus.rd_addr = 6'(a); cycle(); bus.rd_en = 1'b0;
    check_eq({tag, "_valid"}, bus.rd_valid, 1);
    check_eq({tag, "_key"}, bus.rd_key, k);
    check_eq({tag, "_dur"}, bus.rd_dur, d);
  endtask

  task automatic release_keys();
    bus.key_on = 1'b0; cycle();
  endtask

  initial begin
    bus.key_on = 0; bus.key = 0; bus.start = 0; bus.stop = 0;
    bus.rd_en = 0; bus.rd_addr = 0;
    edge_no = 0; m_onset_edge = 0; m_pkey = 0;
    rst = 1'b1; repeat (2) cycle();
    check_eq("rst_count", bus.note_count, 0);
    check_eq("rst_recording", bus.recording, 0);
    rst = 1'b0; cycle();

    // Single note with a rest: {3,4}, {5,2}
    start_pulse();
    check_eq("t1_recording", bus.recording, 1);
    bus.key_on = 1; bus.key = 3; repeat (10) cycle();
    bus.key_on = 0; repeat (6) cycle();
    bus.key_on = 1; bus.key = 5; repeat (8) cycle();
    stop_pulse();
    check_eq("t1_count", bus.note_count, 2);
    check_eq("t1_rec_off", bus.recording, 0);
    read_expect(0, 3, 4, "t1_s0");
    read_expect(1, 5, 2, "t1_s1");

    // Legato key change: {2,3}, {7,2}
    release_keys();
    start_pulse();
    bus.key_on = 1; bus.key = 2; repeat (12) cycle();
    bus.key = 7; repeat (8) cycle();
    stop_pulse();
    read_expect(0, 2, 3, "t2_s0");
    read_expect(1, 7, 2, "t2_s1");

    // Minimum duration and saturation
    release_keys();
    start_pulse();
    bus.key_on = 1; bus.key = 1; cycle();
    bus.key = 2; repeat (100) cycle();
    bus.key = 3; cycle();
    stop_pulse();
    check_eq("t3_count", bus.note_count, 3);
    read_expect(0, 1, 1, "t3_min");
    read_expect(1, 2, DMAX, "t3_sat");
    read_expect(2, 3, 1, "t3_last");

    // Full: five onsets into four slots
    release_keys();
    start_pulse();
    bus.key_on = 1;
    for (int i = 1; i <= 5; i++) begin
      bus.key = 4'(i); cycle();
      if (i < 5) repeat (3) cycle();
    end
    check_eq("t4_full", bus.full, 1);
    check_eq("t4_count", bus.note_count, 4);
    check_eq("t4_rec_off", bus.recording, 0);
    bus.key = 9; cycle();
    check_eq("t4_count_hold", bus.note_count, 4);
    bus.rd_en = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus.rd_addr = 6'(a); cycle();
      check_eq("t4_b2b_valid", bus.rd_valid, 1);
      check_eq("t4_b2b_key", bus.rd_key, a + 1);
      check_eq("t4_b2b_dur", bus.rd_dur, 1);
    end
    bus.rd_en = 1'b0; cycle();
    check_eq("t4_rd_idle", bus.rd_valid, 0);

    // stop and onset in the same cycle
    release_keys();
    start_pulse();
    check_eq("t5_start_clears_full", bus.full, 0);
    bus.key_on = 1; bus.key = 1; repeat (5) cycle();
    bus.key = 2; bus.stop = 1; cycle(); bus.stop = 0;
    check_eq("t5_stop_onset_count", bus.note_count, 1);
    read_expect(0, 1, 1, "t5_s0");
    // start while recording does not clear
    release_keys();
    start_pulse();
    bus.key_on = 1; bus.key = 4; repeat (8) cycle();
    bus.key = 6; cycle();
    start_pulse();
    check_eq("t5_restart_count", bus.note_count, 1);
    check_eq("t5_restart_rec", bus.recording, 1);
    stop_pulse();
    check_eq("t5_restart_final", bus.note_count, 2);
    // stop while armed
    release_keys();
    start_pulse();
    stop_pulse();
    check_eq("t5_armed_stop_count", bus.note_count, 0);
    check_eq("t5_armed_stop_rec", bus.recording, 0);

    // Reset mid-capture
    start_pulse();
    bus.key_on = 1; bus.key = 8; repeat (5) cycle();
    bus.key = 9; cycle();
    bus.rd_en = 1'b1; bus.rd_addr = 0; cycle(); bus.rd_en = 1'b0;
    rst = 1'b1; cycle(); rst = 1'b0;
    check_eq("t6_rec", bus.recording, 0);
    check_eq("t6_full", bus.full, 0);
    check_eq("t6_count", bus.note_count, 0);
    check_eq("t6_rd_valid", bus.rd_valid, 0);
    check_eq("t6_rd_key", bus.rd_key, 0);
    check_eq("t6_rd_dur", bus.rd_dur, 0);
    release_keys();
    start_pulse();
    bus.key_on = 1; bus.key = 10; repeat (4) cycle();
    bus.key = 11; repeat (4) cycle();
    stop_pulse();
    read_expect(0, 10, 1, "t6_s0");
    read_expect(1, 11, 1, "t6_s1");

    // Randomized stimulus against the model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 5) == 0) bus.key_on = ~bus.key_on;
      if ($urandom_range(0, 9) == 0) bus.key = 4'($urandom_range(0, 15));
      bus.start   = ($urandom_range(0, 19) == 0);
      bus.stop    = ($urandom_range(0, 39) == 0);
      bus.rd_en   = $urandom_range(0, 1) == 1;
      bus.rd_addr = 6'($urandom_range(0, 63));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
